// File: rtl/softex_pkg.sv
// softex_pkg: shared types and FP-format helpers for the softex row masker.
package softex_pkg;
  typedef enum logic [2:0] {
    FP32    = 3'd0,
    FP64    = 3'd1,
    FP16    = 3'd2,
    FP8     = 3'd3,
    FP16ALT = 3'd4
  } fp_format_e;

  localparam fp_format_e FPFORMAT_IN = FP16;
  localparam int ROW_CNT_W = 16;

  typedef struct packed {
    logic [ROW_CNT_W-1:0] row_len;
    logic [ROW_CNT_W-1:0] n_rows;
  } row_masker_cfg_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } row_masker_state_e;

  function automatic int fp_exp_bits(fp_format_e fmt);
    return fmt == FP64 ? 11 : (fmt == FP32 || fmt == FP16ALT) ? 8 : 5;
  endfunction

  function automatic int fp_man_bits(fp_format_e fmt);
    return fmt == FP64 ? 52 : fmt == FP32 ? 23 : fmt == FP16 ? 10 : fmt == FP16ALT ? 7 : 2;
  endfunction

  function automatic int fp_width(fp_format_e fmt);
    return 1 + fp_exp_bits(fmt) + fp_man_bits(fmt);
  endfunction

  // Sign plus all-ones exponent form one contiguous run of ones above a zero mantissa.
  function automatic logic [63:0] fp_neg_inf(fp_format_e fmt);
    return ((64'd1 << (fp_exp_bits(fmt) + 1)) - 64'd1) << fp_man_bits(fmt);
  endfunction
endpackage

// File: rtl/softex_row_masker_lane_mask.sv
// softex_row_masker_lane_mask: tail count to lane mask, padding lanes replaced by -inf.
module softex_row_masker_lane_mask
  import softex_pkg::*;
#(
  parameter fp_format_e FPFORMAT   = FPFORMAT_IN,
  parameter int         VECT_WIDTH = 8,
  localparam int        ELEM_W     = fp_width(FPFORMAT),
  localparam int        TAIL_W     = $clog2(VECT_WIDTH + 1)
) (
  input  logic                         apply_i,
  input  logic [TAIL_W-1:0]            tail_i,
  input  logic [VECT_WIDTH*ELEM_W-1:0] data_i,
  output logic [VECT_WIDTH*ELEM_W-1:0] data_o,
  output logic [VECT_WIDTH-1:0]        mask_o
);
  localparam logic [ELEM_W-1:0] NEG_INF = ELEM_W'(fp_neg_inf(FPFORMAT));

  for (genvar l = 0; l < VECT_WIDTH; l++) begin : g_lane
    assign mask_o[l] = !apply_i || tail_i == '0 || TAIL_W'(l) < tail_i;
    assign data_o[l*ELEM_W +: ELEM_W] = mask_o[l] ? data_i[l*ELEM_W +: ELEM_W] : NEG_INF;
  end
endmodule

// File: rtl/softex_row_masker.sv
// softex_row_masker: splits the beat stream into rows, pads tail lanes with -inf, tags row/job ends; SOFTEX_ROW_MASKER_STATS_EN adds stall_cnt_o.
module softex_row_masker
  import softex_pkg::*;
#(
  parameter int         DATA_WIDTH = 128,
  parameter fp_format_e FPFORMAT   = FPFORMAT_IN,
  parameter int         CNT_W      = ROW_CNT_W,
  localparam int        ELEM_W     = fp_width(FPFORMAT),
  localparam int        VECT_WIDTH = DATA_WIDTH / ELEM_W
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  start_i,
  input  logic [CNT_W-1:0]      row_len_i,
  input  logic [CNT_W-1:0]      n_rows_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic [VECT_WIDTH-1:0] out_mask_o,
  output logic                  out_row_last_o,
  output logic                  out_last_o,
`ifdef SOFTEX_ROW_MASKER_STATS_EN
  output logic [31:0]           stall_cnt_o,
`endif
  output logic                  busy_o,
  output logic                  done_o
);
  localparam int TAIL_W = $clog2(VECT_WIDTH + 1);
  localparam int CW1 = CNT_W + 1;

  if (DATA_WIDTH % ELEM_W != 0) begin : g_dw_chk
    $error("DATA_WIDTH must be a multiple of the element width");
  end
  if (CNT_W != ROW_CNT_W) begin : g_cnt_chk
    $error("CNT_W must match the package row counter width");
  end

  row_masker_state_e state_q, state_d;
  row_masker_cfg_t cfg_q, cfg_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d, row_cnt_q, row_cnt_d, beats_per_row;
  logic [TAIL_W-1:0] tail;
  logic out_valid_q, out_valid_d, out_row_last_q, out_row_last_d, out_last_q, out_last_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d, masked_data;
  logic [VECT_WIDTH-1:0] out_mask_q, out_mask_d, lane_mask;
  logic out_free, in_ready, in_hs, row_end, job_end, start_ok, cfg_empty;

  always_comb begin
    beats_per_row = CNT_W'((CW1'(cfg_q.row_len) + CW1'(VECT_WIDTH - 1)) / CW1'(VECT_WIDTH));
    tail = TAIL_W'(cfg_q.row_len % CNT_W'(VECT_WIDTH));
    out_free = !out_valid_q || out_ready_i;
    in_ready = state_q == RUN && out_free;
    in_hs = in_valid_i && in_ready;
    row_end = beat_cnt_q == beats_per_row - CNT_W'(1);
    job_end = row_end && row_cnt_q == cfg_q.n_rows - CNT_W'(1);
    start_ok = state_q == IDLE && start_i;
    cfg_empty = row_len_i == '0 || n_rows_i == '0;
  end

  softex_row_masker_lane_mask #(
    .FPFORMAT  (FPFORMAT),
    .VECT_WIDTH(VECT_WIDTH)
  ) u_lane_mask (
    .apply_i(row_end),
    .tail_i (tail),
    .data_i (in_data_i),
    .data_o (masked_data),
    .mask_o (lane_mask)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start_i ? (cfg_empty ? DONE : RUN) : IDLE;
      RUN:     state_d = in_hs && job_end ? DRAIN : RUN;
      DRAIN:   state_d = out_free ? DONE : DRAIN;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cfg_d = start_ok ? row_masker_cfg_t'{row_len: row_len_i, n_rows: n_rows_i} : cfg_q;
    beat_cnt_d = start_ok ? '0 : in_hs ? (row_end ? '0 : beat_cnt_q + CNT_W'(1)) : beat_cnt_q;
    row_cnt_d = start_ok ? '0 : (in_hs && row_end) ? row_cnt_q + CNT_W'(1) : row_cnt_q;
    out_valid_d = in_hs || (out_valid_q && !out_ready_i);
    out_data_d = in_hs ? masked_data : out_data_q;
    out_mask_d = in_hs ? lane_mask : out_mask_q;
    out_row_last_d = in_hs ? row_end : out_row_last_q;
    out_last_d = in_hs ? job_end : out_last_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state_q        <= IDLE;
      cfg_q          <= '0;
      beat_cnt_q     <= '0;
      row_cnt_q      <= '0;
      out_valid_q    <= 1'b0;
      out_data_q     <= '0;
      out_mask_q     <= '0;
      out_row_last_q <= 1'b0;
      out_last_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      cfg_q          <= cfg_d;
      beat_cnt_q     <= beat_cnt_d;
      row_cnt_q      <= row_cnt_d;
      out_valid_q    <= out_valid_d;
      out_data_q     <= out_data_d;
      out_mask_q     <= out_mask_d;
      out_row_last_q <= out_row_last_d;
      out_last_q     <= out_last_d;
    end
  end

`ifdef SOFTEX_ROW_MASKER_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = start_ok ? '0 : (out_valid_q && !out_ready_i && stall_cnt_q != '1) ? stall_cnt_q + 32'd1 : stall_cnt_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) stall_cnt_q <= '0;
    else stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

  always_comb begin
    in_ready_o = in_ready;
    out_valid_o = out_valid_q;
    out_data_o = out_data_q;
    out_mask_o = out_mask_q;
    out_row_last_o = out_row_last_q;
    out_last_o = out_last_q;
    busy_o = state_q != IDLE;
    done_o = state_q == DONE;
  end
endmodule

// File: tb/tb_softex_row_masker.sv
// tb_softex_row_masker: directed jobs checked against a row/lane model (FP16 and BF16 instances).
module tb_softex_row_masker;
  import softex_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_i = 1'b1, clear_i = 1'b0, start_i = 1'b0, in_valid_i = 1'b0, out_ready_i = 1'b1;
  logic [15:0] row_len_i = '0, n_rows_i = '0;
  logic [127:0] in_data_i = '0;

  logic in_ready_o, out_valid_o, out_row_last_o, out_last_o, busy_o, done_o;
  logic [127:0] out_data_o;
  logic [7:0] out_mask_o;
  logic b_in_ready, b_out_valid, b_out_row_last, b_out_last, b_busy, b_done;
  logic [127:0] b_out_data;
  logic [7:0] b_out_mask;
`ifdef SOFTEX_ROW_MASKER_STATS_EN
  logic [31:0] stall_cnt_o, b_stall_cnt;
`endif

  softex_row_masker dut (
    .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i), .start_i(start_i),
    .row_len_i(row_len_i), .n_rows_i(n_rows_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .out_mask_o(out_mask_o), .out_row_last_o(out_row_last_o), .out_last_o(out_last_o),
`ifdef SOFTEX_ROW_MASKER_STATS_EN
    .stall_cnt_o(stall_cnt_o),
`endif
    .busy_o(busy_o), .done_o(done_o)
  );

  softex_row_masker #(.FPFORMAT(FP16ALT)) dut_bf16 (
    .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i), .start_i(start_i),
    .row_len_i(row_len_i), .n_rows_i(n_rows_i),
    .in_valid_i(in_valid_i), .in_ready_o(b_in_ready), .in_data_i(in_data_i),
    .out_valid_o(b_out_valid), .out_ready_i(out_ready_i), .out_data_o(b_out_data),
    .out_mask_o(b_out_mask), .out_row_last_o(b_out_row_last), .out_last_o(b_out_last),
`ifdef SOFTEX_ROW_MASKER_STATS_EN
    .stall_cnt_o(b_stall_cnt),
`endif
    .busy_o(b_busy), .done_o(b_done)
  );

  typedef struct packed {
    logic [127:0] d;
    logic [127:0] bd;
    logic [7:0]   m;
    logic         rl;
    logic         l;
  } beat_t;

  beat_t expq[$];
  beat_t rec[$];
  int n_tests = 0, n_fail = 0, cyc = 0, done_cyc = -1, last_pop_cyc = -10;
  int mdl_k = 0, mdl_rl = 0, mdl_nr = 0, mdl_total = 0;
  logic mdl_busy = 1'b0, mdl_active = 1'b0, exp_done = 1'b0;

  function automatic logic [127:0] pat(input int i);
    logic [127:0] v;
    for (int l = 0; l < 8; l++) v[16*l +: 16] = 16'(i * 16 + l + 1);
    return v;
  endfunction

  // Expected beat k of a job: row = k / beats_per_row, lanes past the row's element count are padding.
  function automatic beat_t model_beat(input int k, input int rl, input int nr, input logic [127:0] d);
    beat_t e;
    int bpr, b, r, nv;
    bpr = (rl + 7) / 8;
    b = k % bpr;
    r = k / bpr;
    nv = (b == bpr - 1) ? rl - 8 * (bpr - 1) : 8;
    e.m = 8'((1 << nv) - 1);
    for (int l = 0; l < 8; l++) begin
      e.d[16*l +: 16] = (l < nv) ? d[16*l +: 16] : 16'hFC00;
      e.bd[16*l +: 16] = (l < nv) ? d[16*l +: 16] : 16'hFF80;
    end
    e.rl = (b == bpr - 1);
    e.l = e.rl && (r == nr - 1);
    return e;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin : cmp
    logic nd, exp_rdy;
    cyc++;
    if (rst_i || clear_i) begin
      expq.delete();
      mdl_busy = 1'b0;
      mdl_active = 1'b0;
      exp_done = 1'b0;
    end else begin
      nd = 1'b0;
      exp_rdy = mdl_active && (expq.size() == 0 || out_ready_i);
      chk("busy", busy_o, mdl_busy);
      chk("done", done_o, exp_done);
      chk("in_ready", in_ready_o, exp_rdy);
      chk("bf16_in_ready", b_in_ready, exp_rdy);
      chk("out_valid", out_valid_o, expq.size() != 0);
      chk("bf16_out_valid", b_out_valid, expq.size() != 0);
      if (done_o) done_cyc = cyc;
      if (expq.size() != 0) begin
        chk("out_data", out_data_o, expq[0].d);
        chk("out_mask", out_mask_o, expq[0].m);
        chk("out_flags", {out_row_last_o, out_last_o}, {expq[0].rl, expq[0].l});
        chk("bf16_out_data", b_out_data, expq[0].bd);
        if (out_ready_i) begin
          rec.push_back(beat_t'{d: out_data_o, bd: b_out_data, m: out_mask_o, rl: out_row_last_o, l: out_last_o});
          nd = expq[0].l;
          if (nd) last_pop_cyc = cyc;
          void'(expq.pop_front());
        end
      end
      if (in_valid_i && in_ready_o && mdl_active) begin
        expq.push_back(model_beat(mdl_k, mdl_rl, mdl_nr, in_data_i));
        mdl_k++;
        if (mdl_k == mdl_total) mdl_active = 1'b0;
      end
      if (start_i && !mdl_busy) begin
        mdl_rl = int'(row_len_i);
        mdl_nr = int'(n_rows_i);
        mdl_k = 0;
        mdl_total = ((mdl_rl + 7) / 8) * mdl_nr;
        mdl_busy = 1'b1;
        if (mdl_total == 0) nd = 1'b1;
        else mdl_active = 1'b1;
      end
      if (exp_done) mdl_busy = 1'b0;
      exp_done = nd;
    end
  end

  task automatic start_job(input int rl, input int nr);
    @(posedge clk); #1;
    rec.delete();
    row_len_i = 16'(rl);
    n_rows_i = 16'(nr);
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic feed(input int n, input bit rnd);
    int i, t;
    bit seen, hs;
    i = 0; t = 0; seen = 0;
    while ((i < n || !seen) && t < 3000) begin
      in_valid_i = i < n;
      in_data_i = pat(i);
      out_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      hs = in_valid_i && in_ready_o;
      if (done_o) seen = 1;
      @(posedge clk); #1;
      if (hs) i++;
      t++;
    end
    in_valid_i = 1'b0;
    out_ready_i = 1'b1;
    if (t >= 3000) begin
      n_tests++; n_fail++;
      $display("FAIL feed_timeout: got %0d beats, want %0d", i, n);
    end
  endtask

  initial begin
    bit seen, hs;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid_o, 0);
    chk("rst_out_data", out_data_o, 0);
    chk("rst_out_mask", out_mask_o, 0);
    chk("rst_flags", {out_row_last_o, out_last_o, busy_o, done_o, in_ready_o}, 0);
`ifdef SOFTEX_ROW_MASKER_STATS_EN
    chk("rst_stall_cnt", stall_cnt_o, 0);
`endif

    start_job(20, 2);
    feed(6, 0);
    chk("t1_count", rec.size(), 6);
    chk("t1_b2_mask", rec[2].m, 8'h0F);
    chk("t1_b2_pad", rec[2].d[127:64], {4{16'hFC00}});
    chk("t1_b2_keep", rec[2].d[63:0], 64'h0024_0023_0022_0021);
    chk("t1_b2_flags", {rec[2].rl, rec[2].l}, 2'b10);
    chk("t1_b5_flags", {rec[5].rl, rec[5].l}, 2'b11);
    chk("t1_b5_mask", rec[5].m, 8'h0F);
    chk("t1_b0_mask", rec[0].m, 8'hFF);
    chk("t1_done_lat", done_cyc - last_pop_cyc, 1);

    start_job(16, 3);
    feed(6, 0);
    chk("t2_count", rec.size(), 6);
    for (int i = 0; i < 6; i++) begin
      chk("t2_mask", rec[i].m, 8'hFF);
      chk("t2_flags", {rec[i].rl, rec[i].l}, {i % 2 == 1, i == 5});
    end
    chk("t2_b3_data", rec[3].d, pat(3));

    start_job(5, 4);
    @(posedge clk); #1;
    row_len_i = '0;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    feed(4, 1);
    chk("t3_count", rec.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("t3_mask", rec[i].m, 8'h1F);
      chk("t3_pad", rec[i].d[127:80], {3{16'hFC00}});
    end

    start_job(0, 3);
    seen = 0;
    in_valid_i = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (done_o) seen = 1;
      chk("t4_in_ready", in_ready_o, 0);
      @(posedge clk); #1;
    end
    in_valid_i = 1'b0;
    chk("t4_done_seen", seen, 1);
    chk("t4_no_output", rec.size(), 0);

    start_job(20, 2);
    in_valid_i = 1'b1;
    in_data_i = pat(0);
    @(posedge clk); #1;
    in_data_i = pat(1);
    clear_i = 1'b1;
    @(posedge clk); #1;
    clear_i = 1'b0;
    in_valid_i = 1'b0;
    @(negedge clk);
    chk("t5_out_valid", out_valid_o, 0);
    chk("t5_busy", busy_o, 0);
    chk("t5_done", done_o, 0);
    repeat (3) @(negedge clk);
    start_job(20, 2);
    feed(6, 0);
    chk("t5_rerun_count", rec.size(), 6);
    chk("t5_rerun_last", {rec[5].rl, rec[5].l}, 2'b11);

    start_job(3, 2);
    feed(2, 0);
    chk("t6_bf16_pad", rec[0].bd[127:48], {5{16'hFF80}});
    chk("t6_bf16_keep", rec[0].bd[47:0], 48'h0003_0002_0001);
    chk("t6_fp16_pad", rec[1].d[127:48], {5{16'hFC00}});
    chk("t6_mask", rec[1].m, 8'h07);
    chk("t6_flags", {rec[1].rl, rec[1].l}, 2'b11);

    start_job(8, 1);
    in_valid_i = 1'b1;
    out_ready_i = 1'b0;
    in_data_i = pat(0);
    hs = 0;
    for (int t = 0; t < 20 && !hs; t++) begin
      @(negedge clk);
      hs = in_ready_o;
      @(posedge clk); #1;
    end
    in_valid_i = 1'b0;
    chk("t7_accepted", hs, 1);
    repeat (7) @(posedge clk);
    #1 out_ready_i = 1'b1;
    seen = 0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk);
      if (done_o) seen = 1;
    end
    chk("t7_done_seen", seen, 1);
    chk("t7_count", rec.size(), 1);
`ifdef SOFTEX_ROW_MASKER_STATS_EN
    chk("t7_stall_cnt", stall_cnt_o, 7);
`endif

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
